// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat round controller.
package baccarat_pkg;

  localparam int NATURAL_MIN_DEF = 8;
  localparam int DRAW_MAX_DEF    = 5;

  typedef enum logic [3:0] {
    RST     = 4'd0,
    DEAL_P1 = 4'd1,
    DEAL_D1 = 4'd2,
    DEAL_P2 = 4'd3,
    DEAL_D2 = 4'd4,
    EVAL    = 4'd5,
    DEAL_P3 = 4'd6,
    EVAL_D  = 4'd7,
    DEAL_D3 = 4'd8,
    RESULT  = 4'd9,
    DONE    = 4'd10
  } state_t;

  // Tens and court cards count as zero; unused codes 14/15 fold to zero too.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction

endpackage

// File: rtl/baccarat_game_fsm_if.sv
// Connection between the round controller and the card/score datapath.
interface baccarat_game_fsm_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3_in;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       game_done;

  modport master (
    input  pscore, dscore, pcard3_in,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, game_done
  );

  modport slave (
    output pscore, dscore, pcard3_in,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, game_done
  );
endinterface

// File: rtl/baccarat_game_fsm_banker_draw_rule.sv
// Dealer third-card tableau: decides a dealer draw from the dealer two-card
// score and the value of the player's third card.
module banker_draw_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3_val,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pcard3_val != 4'd8);
      4'd4:             draw = (pcard3_val >= 4'd2) && (pcard3_val <= 4'd7);
      4'd5:             draw = (pcard3_val >= 4'd4) && (pcard3_val <= 4'd7);
      4'd6:             draw = (pcard3_val >= 4'd6) && (pcard3_val <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_game_fsm.sv
// Baccarat round controller: sequences card loads, applies the tableau and
// latches the winner lights until reset.
//
// state   | meaning
// RST     | idle after reset, lights cleared
// DEAL_P1 | load player card 1
// DEAL_D1 | load dealer card 1
// DEAL_P2 | load player card 2
// DEAL_D2 | load dealer card 2
// EVAL    | two-card scores valid: natural / player draw / dealer draw
// DEAL_P3 | load player card 3
// EVAL_D  | dealer tableau against player third card
// DEAL_D3 | load dealer card 3
// RESULT  | compare final scores, lights registered on exit
// DONE    | hold lights until reset
module baccarat_game_fsm
  import baccarat_pkg::*;
#(
  parameter int NATURAL_MIN = NATURAL_MIN_DEF,
  parameter int DRAW_MAX    = DRAW_MAX_DEF
) (
  input  logic                       slow_clock,
  input  logic                       resetb,
  baccarat_game_fsm_if.master        bus
);

  localparam logic [3:0] NAT_MIN = 4'(NATURAL_MIN);
  localparam logic [3:0] DRW_MAX = 4'(DRAW_MAX);

  state_t state_q, state_d;
  logic   player_q, player_d;
  logic   dealer_q, dealer_d;
  logic   done_q, done_d;
  logic   dealer_draw;

  banker_draw_rule u_draw_rule (
    .dscore     (bus.dscore),
    .pcard3_val (card_value(bus.pcard3_in)),
    .draw       (dealer_draw)
  );

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= RST;
      player_q <= 1'b0;
      dealer_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      dealer_q <= dealer_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    dealer_d = dealer_q;
    done_d   = done_q;
    case (state_q)
      RST: begin
        state_d  = DEAL_P1;
        player_d = 1'b0;
        dealer_d = 1'b0;
        done_d   = 1'b0;
      end
      DEAL_P1: state_d = DEAL_D1;
      DEAL_D1: state_d = DEAL_P2;
      DEAL_P2: state_d = DEAL_D2;
      DEAL_D2: state_d = EVAL;
      EVAL: begin
        if (bus.pscore >= NAT_MIN || bus.dscore >= NAT_MIN)
          state_d = RESULT;
        else if (bus.pscore <= DRW_MAX)
          state_d = DEAL_P3;
        else if (bus.dscore <= DRW_MAX)
          state_d = DEAL_D3;
        else
          state_d = RESULT;
      end
      DEAL_P3: state_d = EVAL_D;
      EVAL_D:  state_d = dealer_draw ? DEAL_D3 : RESULT;
      DEAL_D3: state_d = RESULT;
      RESULT: begin
        state_d  = DONE;
        player_d = (bus.pscore >= bus.dscore);
        dealer_d = (bus.dscore >= bus.pscore);
        done_d   = 1'b1;
      end
      DONE:    state_d = DONE;
      default: state_d = RST;
    endcase
  end

  assign bus.load_pcard1      = (state_q == DEAL_P1);
  assign bus.load_dcard1      = (state_q == DEAL_D1);
  assign bus.load_pcard2      = (state_q == DEAL_P2);
  assign bus.load_dcard2      = (state_q == DEAL_D2);
  assign bus.load_pcard3      = (state_q == DEAL_P3);
  assign bus.load_dcard3      = (state_q == DEAL_D3);
  assign bus.player_win_light = player_q;
  assign bus.dealer_win_light = dealer_q;
  assign bus.game_done        = done_q;

endmodule

// File: tb/tb_baccarat_game_fsm.sv
// Self-checking bench for baccarat_game_fsm with a result scoreboard and a
// standalone sweep of the dealer draw table.
module tb_baccarat_game_fsm;

  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;

  baccarat_game_fsm_if bus ();

  baccarat_game_fsm u_dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus)
  );

  logic [3:0] rule_d;
  logic [3:0] rule_v;
  logic       rule_draw;

  banker_draw_rule u_rule (
    .dscore     (rule_d),
    .pcard3_val (rule_v),
    .draw       (rule_draw)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct {
    logic pl;
    logic dl;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  wire [5:0] loads = {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
                      bus.load_dcard2, bus.load_pcard3, bus.load_dcard3};
  wire [8:0] outs  = {loads, bus.player_win_light, bus.dealer_win_light, bus.game_done};

  // Plays one round from reset: a tiny datapath model swaps in the final
  // scores when the third-card loads are seen.
  task automatic run_round(input logic [3:0] p2, input logic [3:0] d2,
                           input logic [3:0] rank, input logic [3:0] pfin,
                           input logic [3:0] dfin, output logic pl, output logic dl,
                           output int cyc, output int cnt [6], output bit multi);
    bus.pscore    = p2;
    bus.dscore    = d2;
    bus.pcard3_in = rank;
    resetb = 1'b0;
    @(negedge slow_clock);
    @(negedge slow_clock);
    resetb = 1'b1;
    cyc   = -1;
    multi = 1'b0;
    for (int k = 0; k < 6; k++) cnt[k] = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge slow_clock);
      for (int k = 0; k < 6; k++) if (loads[5-k]) cnt[k]++;
      if ($countones(loads) > 1) multi = 1'b1;
      if (bus.load_pcard3) bus.pscore = pfin;
      if (bus.load_dcard3) bus.dscore = dfin;
      if (bus.game_done) begin
        cyc = i;
        break;
      end
    end
    pl = bus.player_win_light;
    dl = bus.dealer_win_light;
  endtask

  function automatic logic [3:0] tb_value(input logic [3:0] rank);
    return (rank > 4'd9) ? 4'd0 : rank;
  endfunction

  function automatic logic tb_draw(input int d, input int v);
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d == 4) return v >= 2 && v <= 7;
    if (d == 5) return v >= 4 && v <= 7;
    if (d == 6) return v >= 6 && v <= 7;
    return 1'b0;
  endfunction

  task automatic test_reset();
    bus.pscore = 4'd0; bus.dscore = 4'd0; bus.pcard3_in = 4'd0;
    resetb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge slow_clock);
      n_checks++;
      if (outs !== 9'd0) $display("FAIL reset_outputs cycle %0d got %b exp 000000000", i, outs);
      else n_pass++;
    end
  endtask

  task automatic test_natural();
    logic pl, dl; int cyc; int cnt [6]; bit multi; exp_t e;
    sb.push_back('{pl: 1'b1, dl: 1'b0});
    run_round(4'd8, 4'd3, 4'd0, 4'd8, 4'd3, pl, dl, cyc, cnt, multi);
    n_checks++;
    if (cyc !== 7) $display("FAIL natural_latency got %0d exp 7", cyc);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (cnt[k] !== 1) $display("FAIL natural_load%0d_count got %0d exp 1", k, cnt[k]);
      else n_pass++;
    end
    n_checks++;
    if (cnt[4] + cnt[5] !== 0) $display("FAIL natural_third_loads got %0d exp 0", cnt[4] + cnt[5]);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({pl, dl, bus.game_done} !== {e.pl, e.dl, 1'b1})
      $display("FAIL natural_lights got %b%b%b exp %b%b1", pl, dl, bus.game_done, e.pl, e.dl);
    else n_pass++;
  endtask

  task automatic test_player_draw();
    logic pl, dl; int cyc; int cnt [6]; bit multi; exp_t e;
    sb.push_back('{pl: 1'b0, dl: 1'b1});
    run_round(4'd4, 4'd3, 4'd8, 4'd2, 4'd3, pl, dl, cyc, cnt, multi);
    n_checks++;
    if (cyc < 0) $display("FAIL player_draw_timeout got %0d exp done", cyc);
    else n_pass++;
    n_checks++;
    if ({cnt[4], cnt[5]} !== {32'd1, 32'd0})
      $display("FAIL player_draw_loads got p3=%0d d3=%0d exp p3=1 d3=0", cnt[4], cnt[5]);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({pl, dl} !== {e.pl, e.dl}) $display("FAIL player_draw_lights got %b%b exp %b%b", pl, dl, e.pl, e.dl);
    else n_pass++;
  endtask

  task automatic test_stand_tie();
    logic pl, dl; int cyc; int cnt [6]; bit multi; exp_t e;
    sb.push_back('{pl: 1'b1, dl: 1'b1});
    run_round(4'd6, 4'd5, 4'd0, 4'd6, 4'd6, pl, dl, cyc, cnt, multi);
    n_checks++;
    if (cyc !== 8) $display("FAIL stand_tie_latency got %0d exp 8", cyc);
    else n_pass++;
    n_checks++;
    if ({cnt[4], cnt[5]} !== {32'd0, 32'd1})
      $display("FAIL stand_tie_loads got p3=%0d d3=%0d exp p3=0 d3=1", cnt[4], cnt[5]);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({pl, dl} !== {e.pl, e.dl}) $display("FAIL stand_tie_lights got %b%b exp %b%b", pl, dl, e.pl, e.dl);
    else n_pass++;
  endtask

  task automatic test_face_card();
    logic pl, dl; int cyc; int cnt [6]; bit multi; exp_t e;
    sb.push_back('{pl: 1'b0, dl: 1'b1});
    run_round(4'd2, 4'd4, 4'd12, 4'd2, 4'd4, pl, dl, cyc, cnt, multi);
    n_checks++;
    if (cnt[5] !== 0 || cyc < 0) $display("FAIL face_d4_draw got d3=%0d cyc=%0d exp d3=0", cnt[5], cyc);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({pl, dl} !== {e.pl, e.dl}) $display("FAIL face_d4_lights got %b%b exp %b%b", pl, dl, e.pl, e.dl);
    else n_pass++;

    sb.push_back('{pl: 1'b1, dl: 1'b0});
    run_round(4'd2, 4'd3, 4'd12, 4'd2, 4'd1, pl, dl, cyc, cnt, multi);
    n_checks++;
    if (cnt[5] !== 1 || cyc < 0) $display("FAIL face_d3_draw got d3=%0d cyc=%0d exp d3=1", cnt[5], cyc);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({pl, dl} !== {e.pl, e.dl}) $display("FAIL face_d3_lights got %b%b exp %b%b", pl, dl, e.pl, e.dl);
    else n_pass++;
  endtask

  task automatic test_rule_sweep();
    logic exp_draw;
    for (int d = 0; d < 8; d++) begin
      for (int r = 0; r < 14; r++) begin
        rule_d = 4'(d);
        rule_v = tb_value(4'(r));
        exp_draw = tb_draw(d, int'(tb_value(4'(r))));
        #1;
        n_checks++;
        if (rule_draw !== exp_draw)
          $display("FAIL rule_sweep d=%0d rank=%0d got %b exp %b", d, r, rule_draw, exp_draw);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_round();
    bit found;
    bus.pscore = 4'd4; bus.dscore = 4'd3; bus.pcard3_in = 4'd5;
    resetb = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge slow_clock);
      if (bus.load_pcard3) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) $display("FAIL midreset_reach_p3 got 0 exp 1");
    else n_pass++;
    #2 resetb = 1'b0;
    #1;
    n_checks++;
    if (outs !== 9'd0) $display("FAIL midreset_async got %b exp 000000000", outs);
    else n_pass++;
    @(negedge slow_clock);
    resetb = 1'b1;
    #1;
    n_checks++;
    if (outs !== 9'd0) $display("FAIL midreset_rst_state got %b exp 000000000", outs);
    else n_pass++;
    @(negedge slow_clock);
    n_checks++;
    if (loads !== 6'b100000) $display("FAIL midreset_restart got %b exp 100000", loads);
    else n_pass++;
  endtask

  task automatic test_done_hold();
    logic pl, dl; int cyc; int cnt [6]; bit multi; exp_t e;
    sb.push_back('{pl: 1'b1, dl: 1'b0});
    run_round(4'd9, 4'd2, 4'd0, 4'd9, 4'd2, pl, dl, cyc, cnt, multi);
    e = sb.pop_front();
    n_checks++;
    if ({pl, dl, bus.game_done} !== {e.pl, e.dl, 1'b1})
      $display("FAIL hold_initial got %b%b%b exp %b%b1", pl, dl, bus.game_done, e.pl, e.dl);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      bus.pscore    = 4'($urandom_range(0, 15));
      bus.dscore    = 4'($urandom_range(0, 15));
      bus.pcard3_in = 4'($urandom_range(0, 15));
      @(negedge slow_clock);
      n_checks++;
      if (outs !== {6'd0, e.pl, e.dl, 1'b1})
        $display("FAIL done_hold cycle %0d got %b exp %b", i, outs, {6'd0, e.pl, e.dl, 1'b1});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic pl, dl; int cyc; int cnt [6]; bit multi; exp_t e;
    sb.push_back('{pl: 1'b0, dl: 1'b1});
    sb.push_back('{pl: 1'b1, dl: 1'b0});

    run_round(4'd1, 4'd2, 4'd5, 4'd6, 4'd7, pl, dl, cyc, cnt, multi);
    n_checks++;
    if ({cnt[4], cnt[5]} !== {32'd1, 32'd1} || multi)
      $display("FAIL both_draw_loads got p3=%0d d3=%0d multi=%0d exp 1 1 0", cnt[4], cnt[5], multi);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({pl, dl} !== {e.pl, e.dl} || cyc < 0)
      $display("FAIL both_draw_lights got %b%b cyc=%0d exp %b%b", pl, dl, cyc, e.pl, e.dl);
    else n_pass++;

    run_round(4'd7, 4'd6, 4'd0, 4'd7, 4'd6, pl, dl, cyc, cnt, multi);
    n_checks++;
    if (cyc !== 7) $display("FAIL stand_stand_latency got %0d exp 7", cyc);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({pl, dl} !== {e.pl, e.dl}) $display("FAIL stand_stand_lights got %b%b exp %b%b", pl, dl, e.pl, e.dl);
    else n_pass++;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    rule_d = 4'd0;
    rule_v = 4'd0;
    test_reset();
    test_natural();
    test_player_draw();
    test_stand_tie();
    test_face_card();
    test_rule_sweep();
    test_reset_mid_round();
    test_done_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
